// File: rtl/fp_pkg.sv
// Shared floating-point types and constants: sign, exponent and a fraction with an explicit
// leading 1, where the value is 0.frac * 2^exp.
package fp_pkg;

  localparam int unsigned EXP_W  = 4;
  localparam int unsigned FRAC_W = 8;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_NORM,
    ST_ROUND,
    ST_DONE
  } state_t;

  localparam fp_t FP_ZERO    = '{sign: 1'b0, exp: '0, frac: '0};
  localparam fp_t FP_MAX_POS = '{sign: 1'b0, exp: '1, frac: '1};
  localparam fp_t FP_MAX_NEG = '{sign: 1'b1, exp: '1, frac: '1};

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalized fraction, with fraction carry into the exponent and
// saturation to the largest representable magnitude on exponent overflow.
module fp_round_rne #(
  parameter int unsigned EXP_W  = 4,
  parameter int unsigned FRAC_W = 8
) (
  input  logic [FRAC_W-1:0] frac,
  input  logic              guard,
  input  logic              sticky,
  input  logic [EXP_W-1:0]  exp,
  output logic [FRAC_W-1:0] rnd_frac_c,
  output logic [EXP_W-1:0]  rnd_exp_c
);

  localparam int unsigned SUM_W = FRAC_W + 1;
  localparam int unsigned EXI_W = EXP_W + 1;

  logic [SUM_W-1:0] sum_c;
  logic [EXI_W-1:0] exp_inc_c;

  always_comb begin
    sum_c      = {1'b0, frac} + SUM_W'(guard & (frac[0] | sticky));
    exp_inc_c  = {1'b0, exp} + EXI_W'(1);
    rnd_frac_c = sum_c[FRAC_W-1:0];
    rnd_exp_c  = exp;
    if (sum_c[FRAC_W]) begin
      if (exp_inc_c[EXP_W]) begin
        rnd_frac_c = '1;
        rnd_exp_c  = '1;
      end else begin
        rnd_frac_c = {1'b1, {(FRAC_W-1){1'b0}}};
        rnd_exp_c  = exp_inc_c[EXP_W-1:0];
      end
    end
  end

endmodule

// File: rtl/int_to_fp.sv
// Serial signed-integer to floating-point converter: normalizes one bit per cycle, then
// rounds to nearest even. Valid/ready handshakes on both sides.
module int_to_fp
  import fp_pkg::*;
#(
  parameter int unsigned IN_W   = 16,
  parameter int unsigned EXP_W  = fp_pkg::EXP_W,
  parameter int unsigned FRAC_W = fp_pkg::FRAC_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [FRAC_W-1:0] out_frac,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned MAG_W = IN_W - 1;
  localparam int unsigned GRD   = MAG_W - FRAC_W - 1;

  state_t             state;
  logic [MAG_W-1:0]   mag;
  logic [EXP_W-1:0]   expcnt;
  logic               sign;
  logic [IN_W-1:0]    abs_in_c;
  logic [FRAC_W-1:0]  rnd_frac_c;
  logic [EXP_W-1:0]   rnd_exp_c;

  assign in_ready = (state == ST_IDLE);
  assign abs_in_c = in_data[IN_W-1] ? (~in_data + IN_W'(1)) : in_data;

  fp_round_rne #(
    .EXP_W  (EXP_W),
    .FRAC_W (FRAC_W)
  ) u_round (
    .frac       (mag[MAG_W-1 -: FRAC_W]),
    .guard      (mag[GRD]),
    .sticky     (|mag[GRD-1:0]),
    .exp        (expcnt),
    .rnd_frac_c (rnd_frac_c),
    .rnd_exp_c  (rnd_exp_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      mag       <= '0;
      expcnt    <= '0;
      sign      <= 1'b0;
      out_sign  <= 1'b0;
      out_exp   <= '0;
      out_frac  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            sign   <= in_data[IN_W-1];
            expcnt <= '1;
            // Zero and most-negative inputs bypass normalization entirely.
            if (abs_in_c == '0) begin
              {out_sign, out_exp, out_frac} <= FP_ZERO;
              state <= ST_DONE;
            end else if (abs_in_c[IN_W-1]) begin
              {out_sign, out_exp, out_frac} <= FP_MAX_NEG;
              state <= ST_DONE;
            end else begin
              mag   <= abs_in_c[MAG_W-1:0];
              state <= ST_NORM;
            end
          end
        end
        ST_NORM: begin
          if (mag[MAG_W-1]) begin
            state <= ST_ROUND;
          end else begin
            mag    <= mag << 1;
            expcnt <= expcnt - EXP_W'(1);
          end
        end
        ST_ROUND: begin
          out_sign  <= sign;
          out_exp   <= rnd_exp_c;
          out_frac  <= rnd_frac_c;
          out_valid <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          // Bypass results enter DONE with out_valid low; it rises one cycle later.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/int_to_fp.md
Name: int_to_fp

Overview:
- Sequential converter from signed two's-complement integers to the team's 13-bit floating-point format: sign, 4-bit exponent, 8-bit fraction with explicit leading 1.
- Value of a result is 0.frac × 2^exp.
- Sits directly upstream of the floating-point adder and produces operands in exactly the format the adder consumes.
- Normalizes serially, one bit per cycle, then rounds to nearest even; valid/ready handshakes on both sides.

Parameters:
- IN_W, 16, input integer width; magnitude must fit IN_W-1 bits.
- EXP_W, 4, exponent width; must satisfy IN_W-1 <= 2^EXP_W - 1.
- FRAC_W, 8, fraction width, MSB is the explicit leading 1.
- Only the defaults are verified.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_data  in  IN_W  signed integer operand.
- in_valid  in  1  operand valid.
- in_ready  out  1  converter can accept; high only in IDLE.
- out_sign  out  1  result sign.
- out_exp  out  EXP_W  result exponent.
- out_frac  out  FRAC_W  result fraction.
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  downstream accepts.

Behaviour:
- Reset: state IDLE; out_valid=0, out_sign=0, out_exp=0, out_frac=0; in_ready=1 (combinational from IDLE). Reset asserted in any state aborts the conversion immediately and discards the operand.
- Handshake: transfer occurs when valid & ready are both high at a rising edge. in_ready is high only in IDLE. Output fields are registered and stable while out_valid=1.
- FSM states: IDLE, NORM, ROUND, DONE.
- IDLE, on accept, computes sign and magnitude |in_data| (IN_W bits) and sets expcnt = 2^EXP_W - 1.
  - magnitude == 0: sign=0, exp=0, frac=0; go to DONE.
  - magnitude >= 2^(IN_W-1) (only -32768): saturate to sign=1, exp=15, frac=0xFF; go to DONE.
  - otherwise: load mag[IN_W-2:0] into the shift register; go to NORM.
- NORM, while mag[14]==0: shift mag left 1 and decrement expcnt each cycle. When mag[14]==1, go to ROUND. The shift count s = 14 - p, where p is the leading-1 position; s ranges 0..14.
- ROUND computes the result from the normalized mag:
  - frac = mag[14:7]; guard = mag[6]; sticky = |mag[5:0].
  - Increment frac if guard & (frac[0] | sticky), i.e. nearest even.
  - Carry out of frac: frac=0x80, exp=expcnt+1.
  - If that exponent exceeds 15: saturate exp=15, frac=0xFF.
  - Go to DONE.
- DONE: out_valid=1. On out_ready, go to IDLE with out_valid=0 at the next edge. A new operand can be accepted no earlier than the cycle after return to IDLE.
- Latency, measured from the accept edge k:
  - out_valid rises at edge k+s+2.
  - Zero and saturation cases: edge k+1.
  - Worst case (in=±1): k+16.
- in_data changes while the block is busy are ignored.

Decomposition:
- Package fp_pkg:
  - EXP_W, FRAC_W.
  - Packed fp_t typedef {sign, exp, frac}.
  - FSM state enum.
  - Constants FP_ZERO and FP_MAX_POS/FP_MAX_NEG (exp=15, frac=0xFF).
- Sub-module fp_round_rne: combinational; takes frac, guard, sticky and exp; returns rounded frac and exp with carry handling and saturation. Instantiated in ROUND, and reusable by later arithmetic blocks.

Test Plan:
- in=1 -> out sign0 exp1 frac0x80; out_valid exactly 16 cycles after accept; in_ready low throughout.
- in=-300 -> sign1 exp9 frac0x96. in=0 -> sign0 exp0 frac0x00 one cycle after accept.
- RNE rounding:
  - in=257 -> exp9 frac0x80 (tie, even).
  - in=259 -> exp9 frac0x82 (tie, odd rounds up).
  - in=511 -> exp10 frac0x80 (rounding carry).
- Saturation:
  - in=32767 -> sign0 exp15 frac0xFF (rounding overflow), reached via ROUND.
  - in=-32768 -> sign1 exp15 frac0xFF one cycle after accept.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in DONE -> outputs and out_valid stable, in_ready=0, new in_valid ignored.
  - Release out_ready -> IDLE next cycle; following operand converted correctly.
- Reset mid-NORM: assert reset_n=0 during the conversion of in=1 -> out_valid=0 and in_ready=1 without waiting for a clock edge. After release, in=-2 converts to sign1 exp2 frac0x80.
